flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
- Shares the single Avalon-MM flash read port between two requesters: requester 0 is the audio sample fetch FSM, requester 1 is the auxiliary reader (LCD/picoblaze table fetch).
- Round-robin arbitration. One outstanding flash read at a time.
- Issues the read, waits for readdatavalid, then returns the 32-bit word to the owner with a one-cycle done pulse.
- Sits between the requester FSMs and the flash controller IP.

Parameters:
- ADDR_W, 23, flash word address width
- DATA_W, 32, flash data width
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with FLASH_ARB_TIMEOUT_EN)

Ports:
- CLK_50M  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req0  input  1  requester 0 read request, level; held high until done0
- addr0  input  ADDR_W  requester 0 word address; stable while req0 high
- gnt0  output  1  requester 0 owns the flash port
- done0  output  1  one-cycle pulse: rdata valid for requester 0
- err0  output  1  one-cycle pulse with done0 on timeout
- req1, addr1, gnt1, done1, err1  same as above, requester 1
- rdata  output  DATA_W  registered read data, held until next capture
- busy  output  1  high in any state except IDLE
- flash_read  output  1  Avalon read strobe
- flash_addr  output  ADDR_W  Avalon address
- flash_waitrequest  input  1  Avalon stall
- flash_readdatavalid  input  1  Avalon read data valid
- flash_readdata  input  DATA_W  Avalon read data

Behaviour:
- Clock/reset: one clock, CLK_50M. rst_n is asynchronous, active-low.
- Reset values:
  - all outputs 0; rdata = 0
  - state = IDLE; owner = 0
  - last_owner = 1, so requester 0 wins the first tie
- States: IDLE, ISSUE, WAIT_DATA, DELIVER.
- IDLE:
  - No request: stay in IDLE.
  - Only reqN: owner = N; latch flash_addr = addrN; go to ISSUE.
  - Both req: owner = ~last_owner.
- ISSUE:
  - flash_read = 1; flash_addr held.
  - flash_waitrequest = 1: stay in ISSUE.
  - flash_waitrequest = 0: command accepted; go to WAIT_DATA.
- WAIT_DATA:
  - flash_read = 0.
  - On flash_readdatavalid: rdata <= flash_readdata; go to DELIVER.
- DELIVER:
  - doneN = 1 for exactly one cycle, N = owner.
  - last_owner <= owner; go to IDLE.
- Grant: gntN is high from ISSUE through DELIVER inclusive, for the owner only. gnt0 and gnt1 are never high together.
- Latency:
  - req in cycle 0 (IDLE) → flash_read in cycle 1.
  - With waitrequest = 0 and readdatavalid in cycle 2, done is high in cycle 3.
  - Each extra waitrequest or data-wait cycle adds 1.
- Throughput: at least one IDLE cycle between transactions. With both requests held continuously, grants alternate 0,1,0,1.
- readdatavalid outside WAIT_DATA (stale or spurious) is ignored; rdata is unchanged.
- Requester drops req after grant: the transaction still completes and done still pulses. The requester ignores it.
- Address changes after grant have no effect; the address is latched in IDLE.
- Reset mid-transaction: flash_read and gnt drop immediately (asynchronous). A readdatavalid returning after reset release is ignored (IDLE).
- rdata updates only on capture in WAIT_DATA.

Optional Feature:
- Macro: FLASH_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit (clog2(TIMEOUT_CYC+1)) counter clears on entry to ISSUE and increments each cycle in ISSUE and WAIT_DATA.
  - When the counter reaches TIMEOUT_CYC: rdata <= 0; go to DELIVER, which pulses doneN and errN together.
  - flash_read is deasserted.
  - A later readdatavalid is ignored.
- Undefined: no counter; err0 and err1 tied 0; the arbiter waits indefinitely.

Test Plan:
- Single read: req0=1, addr0=0x000010, waitrequest=0, readdatavalid one cycle after accept with data 0xA1B2C3D4 → flash_addr=0x000010 in cycle 1; done0 pulse in cycle 3; rdata=0xA1B2C3D4; gnt1 never high.
- Tie after reset: req0 and req1 high together → requester 0 granted first; requester 1 granted next; then 0 again; grants alternate for 4 transactions.
- Stall: waitrequest=1 for 5 cycles in ISSUE → flash_read held 6 cycles with flash_addr stable; done arrives 5 cycles later than in the single-read case.
- Spurious readdatavalid in IDLE carrying 0xDEADBEEF → rdata unchanged; no done pulse.
- Reset mid-flight: rst_n low during WAIT_DATA → gnt/flash_read 0 immediately; readdatavalid after release produces no done.
- FLASH_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, readdatavalid never asserted → done1 and err1 pulse together 16 cycles after entering ISSUE; rdata=0; next request is served normally.

Source files
------------

// File: rtl/flash_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// flash_read_arbiter_if
//   Avalon-MM read-only bus between the flash read arbiter and the flash
//   controller IP.
//
//   Signals:
//     flash_read          arbiter -> flash  read strobe
//     flash_addr          arbiter -> flash  word address
//     flash_waitrequest   flash -> arbiter  command stall
//     flash_readdatavalid flash -> arbiter  read data valid
//     flash_readdata      flash -> arbiter  read data
//
//   Handshake: a read command is presented while flash_read is high and is
//   accepted on the first rising edge where flash_waitrequest is low. The
//   response is the single cycle in which flash_readdatavalid is high; the
//   word on flash_readdata is taken in that cycle.
//
//   Modports: master (arbiter side), slave (flash controller side).
// -----------------------------------------------------------------------------
interface flash_read_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) ();
    logic              flash_read;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_waitrequest;
    logic              flash_readdatavalid;
    logic [DATA_W-1:0] flash_readdata;

    modport master (
        output flash_read,
        output flash_addr,
        input  flash_waitrequest,
        input  flash_readdatavalid,
        input  flash_readdata
    );

    modport slave (
        input  flash_read,
        input  flash_addr,
        output flash_waitrequest,
        output flash_readdatavalid,
        output flash_readdata
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// flash_read_arbiter
//   Shares the single Avalon-MM flash read port between requester 0 (audio
//   sample fetch) and requester 1 (auxiliary LCD/picoblaze table reader).
//   Round-robin on ties, one outstanding read at a time. The word returned
//   by the flash is registered in rdata and announced to the owning
//   requester by a one-cycle doneN pulse.
//
//   Ports:
//     CLK_50M, rst_n        clock, asynchronous active-low reset
//     reqN / addrN          level request (held until doneN) and word address
//     gntN                  requester N owns the flash port (ISSUE..DELIVER)
//     doneN                 one-cycle pulse, rdata valid for requester N
//     errN                  one-cycle pulse with doneN on watchdog timeout
//     rdata                 registered read data, held until next capture
//     busy                  high whenever the FSM is not IDLE
//     dbg_state             current FSM state encoding
//     flash                 Avalon-MM master port (flash_read_arbiter_if)
//
//   Build option:
//     FLASH_ARB_TIMEOUT_EN  when defined, a watchdog abandons a read that
//                           has not completed TIMEOUT_CYC cycles after entry
//                           to ISSUE; rdata is cleared and errN pulses with
//                           doneN. When undefined, errN is tied low and the
//                           arbiter waits indefinitely.
// -----------------------------------------------------------------------------
module flash_read_arbiter #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK_50M,
    input  logic              rst_n,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,

    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        dbg_state,

    flash_read_arbiter_if.master flash
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DELIVER   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             tmo_hit;

    // The counter holds 0 in the first ISSUE cycle, so the watchdog fires
    // on the edge where it would have reached TIMEOUT_CYC.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

    // Round-robin: with both requesting, the one that did not go last wins.
    // last_owner resets to 1 so requester 0 wins the first tie.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_owner_q;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            addr_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
`ifdef FLASH_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        timed_out_d  = timed_out_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    addr_d  = pick ? addr1 : addr0;
                    state_d = S_ISSUE;
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
`ifdef FLASH_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
                if (tmo_hit) begin
                    rdata_d     = '0;
                    timed_out_d = 1'b1;
                    state_d     = S_DELIVER;
                end else
`endif
                if (!flash.flash_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
`ifdef FLASH_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // Data arriving in the same cycle as the watchdog still wins.
                if (flash.flash_readdatavalid) begin
                    rdata_d = flash.flash_readdata;
                    state_d = S_DELIVER;
                end
`ifdef FLASH_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d     = '0;
                    timed_out_d = 1'b1;
                    state_d     = S_DELIVER;
                end
`endif
            end
            S_DELIVER: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All handshake outputs decode registered state, so an asynchronous
    // reset drops them immediately.
    assign busy             = (state_q != S_IDLE);
    assign gnt0             = busy && !owner_q;
    assign gnt1             = busy &&  owner_q;
    assign done0            = (state_q == S_DELIVER) && !owner_q;
    assign done1            = (state_q == S_DELIVER) &&  owner_q;
    assign rdata            = rdata_q;
    assign dbg_state        = state_q;
    assign flash.flash_read = (state_q == S_ISSUE);
    assign flash.flash_addr = addr_q;

`ifdef FLASH_ARB_TIMEOUT_EN
    assign err0 = done0 && timed_out_q;
    assign err1 = done1 && timed_out_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_read_arbiter
//   Directed bench for flash_read_arbiter. Stimulus pushes the expected
//   {err, owner, rdata} of every completing read into exp_q; a monitor on
//   the falling edge pops and compares whenever a done pulse appears.
// -----------------------------------------------------------------------------
module tb_flash_read_arbiter;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif
    localparam int W = DATA_W + 2;

    // ---------------- clock / reset ----------------
    logic CLK_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    int cyc = 0;
    always @(posedge CLK_50M) cyc <= cyc + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- DUT ----------------
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              gnt0, gnt1, done0, done1, err0, err1, busy;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        dbg_state;

    flash_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) flash ();

    flash_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
        .CLK_50M   (CLK_50M),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .gnt0      (gnt0),
        .done0     (done0),
        .err0      (err0),
        .req1      (req1),
        .addr1     (addr1),
        .gnt1      (gnt1),
        .done1     (done1),
        .err1      (err1),
        .rdata     (rdata),
        .busy      (busy),
        .dbg_state (dbg_state),
        .flash     (flash.master)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK_50M) begin
        if (rst_n) begin
            if (busy) check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
            if (done0 || done1) begin
                check("done_exclusive", 64'(done0 & done1), 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b required none (cycle %0d)",
                             done0, done1, cyc);
                end else begin
                    check("done_response", 64'({err0 | err1, done1, rdata}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Entered in the first ISSUE cycle; stalls ws cycles, accepts, waits dl
    // cycles, returns data, and leaves the bench in the DELIVER cycle.
    task automatic serve(input int ws, input int dl, input logic [DATA_W-1:0] data,
                         input logic [ADDR_W-1:0] exp_addr);
        for (int i = 0; i <= ws; i++) begin
            flash.flash_waitrequest = (i < ws);
            check("issue_read_addr", 64'({flash.flash_read, flash.flash_addr}), 64'({1'b1, exp_addr}));
            tick();
        end
        flash.flash_waitrequest = 1'b0;
        check("wait_read_low", 64'(flash.flash_read), 64'd0);
        repeat (dl) tick();
        flash.flash_readdatavalid = 1'b1;
        flash.flash_readdata      = data;
        tick();
        flash.flash_readdatavalid = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t0;
        logic [DATA_W-1:0] last_data;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        flash.flash_waitrequest   = 1'b0;
        flash.flash_readdatavalid = 1'b0;
        flash.flash_readdata      = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge CLK_50M);
        #1;
        check("reset_outputs", 64'({gnt0, gnt1, done0, done1, err0, err1, busy, flash.flash_read}), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_addr_state", 64'({flash.flash_addr, dbg_state}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single read, requester 0
        req0 = 1'b1; addr0 = 23'h000010;
        exp_q.push_back({1'b0, 1'b0, 32'hA1B2C3D4});
        t0 = cyc;
        tick();
        check("single_gnt", 64'({gnt1, gnt0}), 64'b01);
        serve(0, 0, 32'hA1B2C3D4, 23'h000010);
        check("single_latency", 64'(cyc - t0), 64'd3);
        check("single_done", 64'({gnt1, done1, done0}), 64'b001);
        check("single_rdata", 64'(rdata), 64'hA1B2C3D4);
        req0 = 1'b0;
        tick();
        check("single_idle", 64'({busy, done0}), 64'd0);

        // Tie after reset: grants alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 23'h000100; addr1 = 23'h000200;
        for (int t = 0; t < 4; t++) begin
            logic o;
            o = t[0];
            exp_q.push_back({1'b0, o, 32'h1000_0000 + 32'(t)});
            tick();
            check("tie_gnt", 64'({gnt1, gnt0}), o ? 64'b10 : 64'b01);
            serve(0, 0, 32'h1000_0000 + 32'(t), o ? 23'h000200 : 23'h000100);
            check("tie_done", 64'({done1, done0}), o ? 64'b10 : 64'b01);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Stall 5 cycles; address changed after grant must not reach the bus
        req0 = 1'b1; addr0 = 23'h2AAAAA;
        exp_q.push_back({1'b0, 1'b0, 32'hC0FFEE01});
        t0 = cyc;
        tick();
        addr0 = 23'h111111;
        serve(5, 0, 32'hC0FFEE01, 23'h2AAAAA);
        check("stall_latency", 64'(cyc - t0), 64'd8);
        check("stall_done", 64'(done0), 64'd1);
        last_data = 32'hC0FFEE01;
        req0 = 1'b0;
        tick();

        // Spurious readdatavalid in IDLE
        flash.flash_readdatavalid = 1'b1;
        flash.flash_readdata      = 32'hDEADBEEF;
        tick();
        flash.flash_readdatavalid = 1'b0;
        tick();
        check("spurious_rdata", 64'(rdata), 64'(last_data));
        check("spurious_idle", 64'(busy), 64'd0);

        // Reset during WAIT_DATA; late readdatavalid ignored
        req1 = 1'b1; addr1 = 23'h000055;
        tick();
        tick();
        check("midflight_wait", 64'({gnt1, flash.flash_read, dbg_state}), 64'({1'b1, 1'b0, 2'd2}));
        rst_n = 1'b0;
        #1;
        check("midflight_async_drop", 64'({gnt0, gnt1, flash.flash_read, busy}), 64'd0);
        req1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        flash.flash_readdatavalid = 1'b1;
        flash.flash_readdata      = 32'h12345678;
        tick();
        flash.flash_readdatavalid = 1'b0;
        tick();
        check("midflight_rdata", 64'(rdata), 64'd0);
        check("midflight_idle", 64'(busy), 64'd0);

`ifdef FLASH_ARB_TIMEOUT_EN
        // Watchdog: no readdatavalid, done1+err1 16 cycles after ISSUE entry
        req1 = 1'b1; addr1 = 23'h000003;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        tick();
        for (int i = 0; i < TMO - 1; i++) tick();
        check("tmo_not_yet", 64'(done1), 64'd0);
        tick();
        check("tmo_done_err", 64'({done1, err1, flash.flash_read}), 64'b110);
        check("tmo_rdata", 64'(rdata), 64'd0);
        req1 = 1'b0;
        tick();
        flash.flash_readdatavalid = 1'b1;
        flash.flash_readdata      = 32'h99999999;
        tick();
        flash.flash_readdatavalid = 1'b0;
        tick();
        check("tmo_late_data", 64'(rdata), 64'd0);
`endif

        // Recovery read on requester 1 at the top address
        req1 = 1'b1; addr1 = 23'h7FFFFF;
        exp_q.push_back({1'b0, 1'b1, 32'hFFFFFFFF});
        t0 = cyc;
        tick();
        check("recover_gnt", 64'({gnt1, gnt0}), 64'b10);
        serve(0, 2, 32'hFFFFFFFF, 23'h7FFFFF);
        check("recover_latency", 64'(cyc - t0), 64'd5);
        check("recover_done", 64'({done1, done0}), 64'b10);
        req1 = 1'b0;
        repeat (3) tick();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
